servo_pwm_posicao: RTL and testbench
====================================

# servo_pwm_posicao

- Converts the sweep position index (0..M-1) into a periodic servo PWM waveform.
- Pulse width is linear in the index. The index is sampled only at period boundaries.
- Emits a one-cycle end-of-period pulse that drives the `conta` input of the up/down sweep counter. This closes the loop: one counter step per PWM period.

## Interface

Parameters:
- `CICLOS_PERIODO`, default 1000000: clocks per PWM period (20 ms at 50 MHz).
- `LARG_MIN`, default 50000: high-time in clocks for index 0 (1 ms).
- `PASSO`, default 1000: extra high-time in clocks per index step.
- `M`, default 50: number of valid positions.
- `N`, default 6: index width.
- `W`, default 20: width of the period counter and of the width register.
- Legal only if LARG_MIN + PASSO*(M-1) < CICLOS_PERIODO < 2^W.

Ports:
- `clock` input 1: single clock; all state changes on its rising edge.
- `zera_as` input 1: asynchronous, active-high reset.
- `zera_s` input 1: synchronous clear; same effect as reset; priority over `liga`.
- `liga` input 1: enable; level-sensitive.
- `posicao` input N: requested position index.
- `pwm` output 1: servo pulse.
- `fim_periodo` output 1: registered one-cycle pulse; marks the end of a completed period.
- `posicao_atual` output N: index (after clamping) currently applied.
- `saturado` output 1: high when the applied index was clamped.

## Operation

Internal state:
- `estado` ∈ {PARADO, ATIVO}
- period counter `cnt` (W bits)
- width register `largura` (W bits)

Reset (`zera_as` or `zera_s`):
- `estado` = PARADO, `cnt` = 0, `largura` = LARG_MIN
- `pwm` = 0, `fim_periodo` = 0, `posicao_atual` = 0, `saturado` = 0

Sampling and clamping:
- Load happens on the edge that starts a period.
- `p` = `posicao` if `posicao` < M, else M-1.
- `largura` <= LARG_MIN + PASSO*`p`, computed at W bits, no overflow by the parameter rule.
- `posicao_atual` <= `p`.
- `saturado` <= (`posicao` >= M).

Transitions:
- PARADO, `liga` = 1: at the next edge go to ATIVO, `cnt` <= 0, load as above. No `fim_periodo` on this start.
- ATIVO, `cnt` < CICLOS_PERIODO-1: `cnt` <= `cnt`+1.
- ATIVO, `cnt` = CICLOS_PERIODO-1:
  - `fim_periodo` <= 1 and `cnt` <= 0.
  - If `liga` = 1, stay ATIVO and load a new width.
  - If `liga` = 0, go to PARADO; `largura` and `posicao_atual` hold.
- `fim_periodo` <= 0 on every other edge.
- Graceful stop: dropping `liga` mid-period never truncates the current period or its pulse.
- `pwm` = (`estado` = ATIVO) and (`cnt` < `largura`), decoded from registers only. It is 0 throughout PARADO.
- Changes to `posicao` within a period have no effect until the next period start.
- `zera_as` asserted mid-pulse forces `pwm` low immediately (asynchronous), whatever the clock.

## Timing

- Period start at edge k:
  - `pwm` high for exactly `largura` cycles (`cnt` = 0..`largura`-1).
  - Low for CICLOS_PERIODO - `largura` cycles.
  - The next period starts at edge k + CICLOS_PERIODO.
- `fim_periodo` is high during the first cycle after the last cycle of a period: `cnt` = 0 of the next period, or the first PARADO cycle.
- Index-to-output latency:
  - `posicao` is sampled only at period-start edges.
  - A value changed mid-period appears in the following period.
  - Worst case CICLOS_PERIODO cycles.
- Sweep loop: `fim_periodo` → `conta` of the sweep counter; its `Q` → `posicao`.
  - The counter updates on the same edge that ends `fim_periodo`.
  - The new index is therefore applied one period later (one-period pipeline lag, intended).
- `liga` pulse of one cycle in PARADO is sufficient to run exactly one full period.

## Test plan

Sim parameters: CICLOS_PERIODO=100, LARG_MIN=10, PASSO=2, M=8, N=4, W=8.

- **Basic period:** reset, `liga`=1, `posicao`=0 → `pwm` high 10 / low 90 cycles, repeating. `fim_periodo` one-cycle pulse every 100 cycles, none on the first start.
- **Maximum and clamping:** `posicao`=7 → high 24 cycles, `saturado`=0. Then `posicao`=12 → next period high 24 cycles, `posicao_atual`=7, `saturado`=1.
- **Mid-period change:** `posicao` 3→5 at `cnt`=50 → current period high 16 cycles; next period high 20 cycles.
- **Graceful stop and restart:** drop `liga` at `cnt`=30 → period runs to 100, `fim_periodo` pulses, state PARADO, `pwm` stays 0. Raise `liga` for one cycle → exactly one more 100-cycle period.
- **Reset during pulse:** assert `zera_as` at `cnt`=5 of a high pulse → `pwm`=0 before the next clock edge. All outputs return to reset values; `largura`=10.
- **Closed loop with the M=8 up/down sweep counter:** `fim_periodo` drives `conta` → successive pulse widths 10,12,…,24,22,…,10,12 cycles. Each value appears one period after the counter steps.

Source files
------------

// File: rtl/servo_pwm_posicao.sv
// Servo PWM generator: turns a sweep position index into a periodic pulse whose
// width is linear in the index, sampled once per period, with an end-of-period strobe.
module servo_pwm_posicao #(
   parameter int CICLOS_PERIODO = 1000000,
   parameter int LARG_MIN       = 50000,
   parameter int PASSO          = 1000,
   parameter int M              = 50,
   parameter int N              = 6,
   parameter int W              = 20
) (
   input  logic         clock,
   input  logic         zera_as,
   input  logic         zera_s,
   input  logic         liga,
   input  logic [N-1:0] posicao,
   output logic         pwm,
   output logic         fim_periodo,
   output logic [N-1:0] posicao_atual,
   output logic         saturado,
   output logic         estado
);

   typedef enum logic {PARADO = 1'b0, ATIVO = 1'b1} estado_t;

   localparam logic [W-1:0] ULTIMO     = W'(CICLOS_PERIODO - 1);
   localparam logic [W-1:0] LARG_BASE  = W'(LARG_MIN);
   localparam logic [W-1:0] PASSO_W    = W'(PASSO);
   localparam logic [N:0]   M_EXT      = (N+1)'(M);
   localparam logic [N-1:0] POS_MAX    = N'(M - 1);

   estado_t      estado_r, estado_n;
   logic [W-1:0] cnt, cnt_n;
   logic [W-1:0] largura, largura_n;
   logic [N-1:0] posicao_atual_n;
   logic         saturado_n;
   logic         fim_n;

   logic         fora_faixa;
   logic [N-1:0] pos_lim;
   logic [W-1:0] largura_calc;

   // Out-of-range requests are clamped to the last valid position.
   assign fora_faixa   = ({1'b0, posicao} >= M_EXT);
   assign pos_lim      = fora_faixa ? POS_MAX : posicao;
   assign largura_calc = LARG_BASE + PASSO_W * W'(pos_lim);

   always_ff @(posedge clock or posedge zera_as) begin
      if (zera_as) begin
         estado_r      <= PARADO;
         cnt           <= '0;
         largura       <= LARG_BASE;
         posicao_atual <= '0;
         saturado      <= 1'b0;
         fim_periodo   <= 1'b0;
      end else begin
         estado_r      <= estado_n;
         cnt           <= cnt_n;
         largura       <= largura_n;
         posicao_atual <= posicao_atual_n;
         saturado      <= saturado_n;
         fim_periodo   <= fim_n;
      end
   end

   always_comb begin
      estado_n        = estado_r;
      cnt_n           = cnt;
      largura_n       = largura;
      posicao_atual_n = posicao_atual;
      saturado_n      = saturado;
      fim_n           = 1'b0;
      if (zera_s) begin
         estado_n        = PARADO;
         cnt_n           = '0;
         largura_n       = LARG_BASE;
         posicao_atual_n = '0;
         saturado_n      = 1'b0;
      end else begin
         case (estado_r)
            PARADO: begin
               if (liga) begin
                  estado_n        = ATIVO;
                  cnt_n           = '0;
                  largura_n       = largura_calc;
                  posicao_atual_n = pos_lim;
                  saturado_n      = fora_faixa;
               end
            end
            ATIVO: begin
               if (cnt == ULTIMO) begin
                  // A period always completes; liga only decides whether another follows.
                  fim_n = 1'b1;
                  cnt_n = '0;
                  if (liga) begin
                     largura_n       = largura_calc;
                     posicao_atual_n = pos_lim;
                     saturado_n      = fora_faixa;
                  end else begin
                     estado_n = PARADO;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            default: estado_n = PARADO;
         endcase
      end
   end

   // Decoded from registers so an asynchronous reset drops the pulse at once.
   assign pwm    = (estado_r == ATIVO) && (cnt < largura);
   assign estado = (estado_r == ATIVO);

endmodule

// File: tb/tb_servo_pwm_posicao.sv
// Directed-plus-random bench for servo_pwm_posicao: per-period pulse measurement
// against an arithmetic width model, plus a closed loop with an up/down sweep counter.
module tb_servo_pwm_posicao;

   localparam int CP = 100;
   localparam int LM = 10;
   localparam int PS = 2;
   localparam int MM = 8;
   localparam int NN = 4;
   localparam int WW = 8;

   logic          clock = 1'b0;
   logic          zera_as = 1'b1;
   logic          zera_s = 1'b0;
   logic          liga = 1'b0;
   logic [NN-1:0] posicao_drv = '0;
   logic [NN-1:0] posicao;
   logic          pwm, fim_periodo, saturado, estado;
   logic [NN-1:0] posicao_atual;

   logic          loop_en = 1'b0;
   logic          sweep_clr = 1'b0;
   logic [NN-1:0] sweep_q = '0;
   logic          sweep_up = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   assign posicao = loop_en ? sweep_q : posicao_drv;

   servo_pwm_posicao #(
      .CICLOS_PERIODO(CP), .LARG_MIN(LM), .PASSO(PS), .M(MM), .N(NN), .W(WW)
   ) dut (
      .clock(clock), .zera_as(zera_as), .zera_s(zera_s), .liga(liga),
      .posicao(posicao), .pwm(pwm), .fim_periodo(fim_periodo),
      .posicao_atual(posicao_atual), .saturado(saturado), .estado(estado)
   );

   // Up/down sweep counter over 0..MM-1, stepped by fim_periodo.
   always @(posedge clock) begin
      if (sweep_clr) begin
         sweep_q  <= '0;
         sweep_up <= 1'b1;
      end else if (loop_en && fim_periodo) begin
         if (sweep_up) begin
            if (sweep_q == NN'(MM - 1)) begin
               sweep_up <= 1'b0;
               sweep_q  <= sweep_q - 1'b1;
            end else sweep_q <= sweep_q + 1'b1;
         end else begin
            if (sweep_q == '0) begin
               sweep_up <= 1'b1;
               sweep_q  <= sweep_q + 1'b1;
            end else sweep_q <= sweep_q - 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp(input int p);
      return (p < MM) ? p : MM - 1;
   endfunction

   function automatic int width_of(input int p);
      return LM + PS * clamp(p);
   endfunction

   // Triangle wave of the sweep counter after a number of steps.
   function automatic int tri_wave(input int steps);
      int t;
      t = steps % (2 * (MM - 1));
      return (t <= MM - 1) ? t : 2 * (MM - 1) - t;
   endfunction

   // Called at the negedge before a period-start edge; returns at the negedge of its last cycle.
   task automatic run_period(input string tag, input int exp_w, input int exp_pos,
                             input int exp_sat, input int exp_fim0, input int drop_at,
                             input int change_at, input int new_pos);
      int highs, lead, fims;
      bit seen_low;
      highs = 0; lead = 0; fims = 0; seen_low = 0;
      for (int i = 0; i < CP; i++) begin
         @(negedge clock);
         if (i == 0) begin
            chk({tag, "_fim0"}, int'(fim_periodo), exp_fim0);
            chk({tag, "_pos"}, int'(posicao_atual), exp_pos);
            chk({tag, "_sat"}, int'(saturado), exp_sat);
            chk({tag, "_estado"}, int'(estado), 1);
         end else if (fim_periodo) fims++;
         if (pwm) begin
            highs++;
            if (!seen_low) lead++;
         end else seen_low = 1;
         if (i == drop_at) liga = 1'b0;
         if (i == change_at) posicao_drv = NN'(new_pos);
      end
      chk({tag, "_highs"}, highs, exp_w);
      chk({tag, "_lead"}, lead, exp_w);
      chk({tag, "_fim_mid"}, fims, 0);
   endtask

   initial begin
      int p, last_pos, idx;

      // Reset state
      #2;
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_fim", int'(fim_periodo), 0);
      chk("rst_pos", int'(posicao_atual), 0);
      chk("rst_sat", int'(saturado), 0);
      chk("rst_estado", int'(estado), 0);
      @(negedge clock);
      zera_as = 1'b0;
      @(negedge clock);
      chk("idle_pwm", int'(pwm), 0);
      chk("idle_estado", int'(estado), 0);

      // Basic period, no strobe on the first start
      liga = 1'b1; posicao_drv = 4'd0;
      run_period("basic1", 10, 0, 0, 0, -1, -1, 0);
      run_period("basic2", 10, 0, 0, 1, -1, -1, 0);

      // Maximum and clamping
      posicao_drv = 4'd7;
      run_period("max", 24, 7, 0, 1, -1, -1, 0);
      posicao_drv = 4'd12;
      run_period("clamp", 24, 7, 1, 1, -1, -1, 0);

      // Mid-period change takes effect only next period
      posicao_drv = 4'd3;
      run_period("mid_a", 16, 3, 0, 1, -1, 50, 5);
      run_period("mid_b", 20, 5, 0, 1, -1, -1, 0);

      // Random positions, back-to-back periods
      for (int k = 0; k < 6; k++) begin
         p = int'($urandom_range(0, 15));
         posicao_drv = NN'(p);
         run_period("rand", width_of(p), clamp(p), (p >= MM) ? 1 : 0, 1, -1, -1, 0);
      end
      last_pos = clamp(p);

      // Graceful stop: liga dropped at cnt=30, period still completes
      run_period("stop", width_of(p), last_pos, (p >= MM) ? 1 : 0, 1, 30, -1, 0);
      @(negedge clock);
      chk("stop_fim", int'(fim_periodo), 1);
      chk("stop_estado", int'(estado), 0);
      chk("stop_pwm", int'(pwm), 0);
      chk("stop_hold_pos", int'(posicao_atual), last_pos);
      repeat (20) @(negedge clock);
      chk("stop_fim_clr", int'(fim_periodo), 0);
      chk("stop_pwm_idle", int'(pwm), 0);

      // One-cycle liga pulse runs exactly one period
      p = int'($urandom_range(0, 7));
      posicao_drv = NN'(p);
      liga = 1'b1;
      run_period("one_shot", width_of(p), p, 0, 0, 0, -1, 0);
      @(negedge clock);
      chk("one_shot_fim", int'(fim_periodo), 1);
      chk("one_shot_estado", int'(estado), 0);
      @(negedge clock);
      chk("one_shot_idle", int'(estado), 0);

      // Asynchronous reset during the high pulse
      posicao_drv = 4'd7; liga = 1'b1;
      for (int i = 0; i < 6; i++) @(negedge clock);
      chk("pre_rst_pwm", int'(pwm), 1);
      zera_as = 1'b1;
      #1;
      chk("async_pwm", int'(pwm), 0);
      chk("async_pos", int'(posicao_atual), 0);
      chk("async_estado", int'(estado), 0);
      @(negedge clock);
      zera_as = 1'b0;

      // Synchronous clear has priority over liga
      zera_s = 1'b1; liga = 1'b1; posicao_drv = 4'd2;
      repeat (3) @(negedge clock);
      chk("sync_estado", int'(estado), 0);
      chk("sync_pwm", int'(pwm), 0);
      zera_s = 1'b0;
      run_period("after_sync", 14, 2, 0, 0, -1, -1, 0);

      // Closed loop with the sweep counter
      @(negedge clock);
      zera_s = 1'b1; sweep_clr = 1'b1; liga = 1'b0;
      @(negedge clock);
      zera_s = 1'b0; sweep_clr = 1'b0; loop_en = 1'b1; liga = 1'b1;
      for (int j = 1; j <= 17; j++) begin
         idx = tri_wave((j < 2) ? 0 : j - 2);
         run_period("loop", LM + PS * idx, idx, 0, (j > 1) ? 1 : 0, -1, -1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
